// File: rtl/send_pkt_pacer_if.sv
// ----------------------------------------------------------------------------
// send_pkt_pacer_if
//
// Groups the two valid/ready channels around the send-packet pacer:
//   mux_pacer_val / mux_pacer_data / pacer_mux_rdy  : mux -> pacer entry channel
//   pacer_dst_val / pacer_dst_data / dst_pacer_rdy  : pacer -> TX stage channel
//
// Modports:
//   slave  : the pacer itself (accepts entries from the mux, drives the TX side)
//   master : the surrounding environment (mux driver and TX stage)
// ----------------------------------------------------------------------------
interface send_pkt_pacer_if #(
    parameter int SEND_PKT_STRUCT_W = 32
);
    logic                         mux_pacer_val;
    logic [SEND_PKT_STRUCT_W-1:0] mux_pacer_data;
    logic                         pacer_mux_rdy;
    logic                         pacer_dst_val;
    logic [SEND_PKT_STRUCT_W-1:0] pacer_dst_data;
    logic                         dst_pacer_rdy;

    modport slave (
        input  mux_pacer_val,
        input  mux_pacer_data,
        output pacer_mux_rdy,
        output pacer_dst_val,
        output pacer_dst_data,
        input  dst_pacer_rdy
    );

    modport master (
        output mux_pacer_val,
        output mux_pacer_data,
        input  pacer_mux_rdy,
        input  pacer_dst_val,
        input  pacer_dst_data,
        output dst_pacer_rdy
    );
endinterface

// File: rtl/send_pkt_pacer.sv
// ----------------------------------------------------------------------------
// send_pkt_pacer
//
// Buffers arbitrated send_pkt_struct entries from the two-source send-packet
// mux in a small first-word-fall-through FIFO and releases them to the TX
// header/assembly stage, inserting a programmable number of idle cycles
// between consecutive output handshakes.
//
// Ports:
//   clk             clock
//   rst             asynchronous reset, active-low
//   pif (slave)     mux entry channel and TX output channel (send_pkt_pacer_if)
//   cfg_gap_cycles  idle cycles forced after each output handshake (0 = none);
//                   sampled only at the handshake
//   fifo_occupancy  number of entries currently buffered (0..FIFO_DEPTH)
//
// Optional feature (define SEND_PKT_PACER_STATS_EN):
//   stat_pkts_sent     saturating count of output handshakes
//   stat_stall_cycles  saturating count of cycles with val high and rdy low
// ----------------------------------------------------------------------------
module send_pkt_pacer #(
    parameter int FIFO_DEPTH        = 8,
    parameter int GAP_W             = 8,
    parameter int SEND_PKT_STRUCT_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    send_pkt_pacer_if.slave               pif,
    input  logic [GAP_W-1:0]              cfg_gap_cycles,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_occupancy
`ifdef SEND_PKT_PACER_STATS_EN
    ,
    output logic [31:0]                   stat_pkts_sent,
    output logic [31:0]                   stat_stall_cycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_GAP   = 1'b1
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [GAP_W-1:0]              gap_cnt;
    logic [GAP_W-1:0]              gap_cnt_next;

    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [OCC_W-1:0]              occ;
    logic [SEND_PKT_STRUCT_W-1:0]  mem [FIFO_DEPTH];

    logic                          full;
    logic                          empty;
    logic                          push;
    logic                          pop;

    // Saturating +1 used by the statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign full  = (occ == FULL_OCC);
    assign empty = (occ == '0);

    // Ready depends only on the registered occupancy (plus reset), so there is
    // no combinational path from dst_pacer_rdy. A pop in the same cycle does
    // not free a slot for a push when full.
    assign pif.pacer_mux_rdy  = rst & !full;

    // Output is gated by the registered occupancy, so an entry written this
    // cycle becomes visible no earlier than the next cycle.
    assign pif.pacer_dst_val  = (state == ST_READY) & !empty;
    assign pif.pacer_dst_data = pif.pacer_dst_val ? mem[rd_ptr] : '0;

    assign push = pif.mux_pacer_val & pif.pacer_mux_rdy;
    assign pop  = pif.pacer_dst_val & pif.dst_pacer_rdy;

    assign fifo_occupancy = occ;

    // Storage: data only, not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pif.mux_pacer_data;
        end
    end

    // FIFO control: pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Pacing FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_READY;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_cnt_next;
        end
    end

    // A handshake with a non-zero gap loads the counter; the counter value N
    // yields exactly N idle cycles because the exit happens on the edge after
    // the counter reads 1.
    always_comb begin
        state_next   = state;
        gap_cnt_next = gap_cnt;
        unique case (state)
            ST_READY: begin
                if (pop && (cfg_gap_cycles != '0)) begin
                    state_next   = ST_GAP;
                    gap_cnt_next = cfg_gap_cycles;
                end
            end
            ST_GAP: begin
                gap_cnt_next = gap_cnt - GAP_W'(1);
                if (gap_cnt == GAP_W'(1)) begin
                    state_next   = ST_READY;
                    gap_cnt_next = '0;
                end
            end
            default: begin
                state_next   = ST_READY;
                gap_cnt_next = '0;
            end
        endcase
    end

`ifdef SEND_PKT_PACER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_pkts_sent    <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (pop) begin
                stat_pkts_sent <= sat_inc(stat_pkts_sent);
            end
            if (pif.pacer_dst_val && !pif.dst_pacer_rdy) begin
                stat_stall_cycles <= sat_inc(stat_stall_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_send_pkt_pacer.sv
// ----------------------------------------------------------------------------
// tb_send_pkt_pacer
//
// Directed bench for send_pkt_pacer: a per-cycle vector table for the basic
// pass-through and gap pacing behaviour, then hand-written sequences for the
// full-FIFO, pointer-wrap, asynchronous-reset and statistics cases.
// ----------------------------------------------------------------------------
module tb_send_pkt_pacer;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int GW    = 8;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [GW-1:0] cfg_gap_cycles;
    logic [OW-1:0] fifo_occupancy;
`ifdef SEND_PKT_PACER_STATS_EN
    logic [31:0]   stat_pkts_sent;
    logic [31:0]   stat_stall_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    send_pkt_pacer_if #(.SEND_PKT_STRUCT_W(W)) pif ();

    send_pkt_pacer #(
        .FIFO_DEPTH       (DEPTH),
        .GAP_W            (GW),
        .SEND_PKT_STRUCT_W(W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pif              (pif),
        .cfg_gap_cycles   (cfg_gap_cycles),
        .fifo_occupancy   (fifo_occupancy)
`ifdef SEND_PKT_PACER_STATS_EN
        ,
        .stat_pkts_sent   (stat_pkts_sent),
        .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    typedef struct {
        logic          mval;
        logic [W-1:0]  mdata;
        logic          drdy;
        logic [GW-1:0] gap;
        logic          exp_mrdy;
        logic          exp_val;
        logic [W-1:0]  exp_data;
        logic [OW-1:0] exp_occ;
    } vec_t;

    vec_t vecs[$];
    logic [W-1:0] model_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [W-1:0] md, input logic dr, input logic [GW-1:0] g);
        pif.mux_pacer_val  = mv;
        pif.mux_pacer_data = md;
        pif.dst_pacer_rdy  = dr;
        cfg_gap_cycles     = g;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, '0, 1'b0, '0);

        // Reset state while rst is held low.
        #12;
        check("rst_mux_rdy", pif.pacer_mux_rdy, 1'b0);
        check("rst_dst_val", pif.pacer_dst_val, 1'b0);
        check("rst_dst_data", pif.pacer_dst_data, '0);
        check("rst_occ", fifo_occupancy, '0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        // Pass-through with gap 0: A,B,C back-to-back.
        vecs.push_back('{1'b1, 32'hAAAA0001, 1'b1, 8'd0, 1'b1, 1'b0, 32'h0,        4'd0});
        vecs.push_back('{1'b1, 32'hAAAA0002, 1'b1, 8'd0, 1'b1, 1'b1, 32'hAAAA0001, 4'd1});
        vecs.push_back('{1'b1, 32'hAAAA0003, 1'b1, 8'd0, 1'b1, 1'b1, 32'hAAAA0002, 4'd1});
        vecs.push_back('{1'b0, 32'h0,        1'b1, 8'd0, 1'b1, 1'b1, 32'hAAAA0003, 4'd1});
        vecs.push_back('{1'b0, 32'h0,        1'b1, 8'd0, 1'b1, 1'b0, 32'h0,        4'd0});
        // Gap 3 with four preloaded entries; cfg changed to 1 mid-gap.
        vecs.push_back('{1'b1, 32'hD0D0_0000, 1'b0, 8'd3, 1'b1, 1'b0, 32'h0,         4'd0});
        vecs.push_back('{1'b1, 32'hD0D0_0001, 1'b0, 8'd3, 1'b1, 1'b1, 32'hD0D0_0000, 4'd1});
        vecs.push_back('{1'b1, 32'hD0D0_0002, 1'b0, 8'd3, 1'b1, 1'b1, 32'hD0D0_0000, 4'd2});
        vecs.push_back('{1'b1, 32'hD0D0_0003, 1'b0, 8'd3, 1'b1, 1'b1, 32'hD0D0_0000, 4'd3});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 8'd3, 1'b1, 1'b1, 32'hD0D0_0000, 4'd4});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 8'd3, 1'b1, 1'b0, 32'h0,         4'd3});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 8'd3, 1'b1, 1'b0, 32'h0,         4'd3});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 8'd3, 1'b1, 1'b0, 32'h0,         4'd3});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 8'd3, 1'b1, 1'b1, 32'hD0D0_0001, 4'd3});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 8'd1, 1'b1, 1'b0, 32'h0,         4'd2});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 8'd1, 1'b1, 1'b0, 32'h0,         4'd2});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 8'd1, 1'b1, 1'b0, 32'h0,         4'd2});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 8'd1, 1'b1, 1'b1, 32'hD0D0_0002, 4'd2});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 8'd1, 1'b1, 1'b0, 32'h0,         4'd1});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 8'd1, 1'b1, 1'b1, 32'hD0D0_0003, 4'd1});
        // Push during the gap, then a gap-0 handshake.
        vecs.push_back('{1'b1, 32'hD0D0_0004, 1'b1, 8'd0, 1'b1, 1'b0, 32'h0,         4'd0});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 8'd0, 1'b1, 1'b1, 32'hD0D0_0004, 4'd1});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 8'd0, 1'b1, 1'b0, 32'h0,         4'd0});

        foreach (vecs[i]) begin
            drive(vecs[i].mval, vecs[i].mdata, vecs[i].drdy, vecs[i].gap);
            @(negedge clk);
            check($sformatf("vec%0d_mux_rdy", i), pif.pacer_mux_rdy, vecs[i].exp_mrdy);
            check($sformatf("vec%0d_dst_val", i), pif.pacer_dst_val, vecs[i].exp_val);
            check($sformatf("vec%0d_dst_data", i), pif.pacer_dst_data, vecs[i].exp_data);
            check($sformatf("vec%0d_occ", i), fifo_occupancy, vecs[i].exp_occ);
            next_cycle();
        end

        // Fill to full with TX stalled; entry 9 waits for the first pop.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'hE000_0000 + i, 1'b0, 8'd0);
            @(negedge clk);
            check($sformatf("full_fill%0d_mux_rdy", i), pif.pacer_mux_rdy, 1'b1);
            next_cycle();
        end
        drive(1'b1, 32'hE000_0008, 1'b0, 8'd0);
        @(negedge clk);
        check("full_mux_rdy", pif.pacer_mux_rdy, 1'b0);
        check("full_occ", fifo_occupancy, 4'd8);
        check("full_head", pif.pacer_dst_data, 32'hE000_0000);
        next_cycle();
        @(negedge clk);
        check("full_hold_mux_rdy", pif.pacer_mux_rdy, 1'b0);
        next_cycle();
        drive(1'b1, 32'hE000_0008, 1'b1, 8'd0);
        @(negedge clk);
        check("full_pop0_mux_rdy", pif.pacer_mux_rdy, 1'b0);
        check("full_pop0_data", pif.pacer_dst_data, 32'hE000_0000);
        next_cycle();
        @(negedge clk);
        check("full_pop1_mux_rdy", pif.pacer_mux_rdy, 1'b1);
        check("full_pop1_occ", fifo_occupancy, 4'd7);
        check("full_pop1_data", pif.pacer_dst_data, 32'hE000_0001);
        next_cycle();
        drive(1'b0, '0, 1'b1, 8'd0);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("full_drain%0d_val", k), pif.pacer_dst_val, 1'b1);
            check($sformatf("full_drain%0d_data", k), pif.pacer_dst_data, 32'hE000_0000 + k);
            next_cycle();
        end
        @(negedge clk);
        check("full_drained_val", pif.pacer_dst_val, 1'b0);
        check("full_drained_occ", fifo_occupancy, 4'd0);
        next_cycle();

        // Steady simultaneous push/pop across pointer wraps.
        model_q.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hF000_0100 + i, 1'b0, 8'd0);
            model_q.push_back(32'hF000_0100 + i);
            next_cycle();
        end
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'hF000_0000 + k, 1'b1, 8'd0);
            @(negedge clk);
            check($sformatf("wrap%0d_val", k), pif.pacer_dst_val, 1'b1);
            check($sformatf("wrap%0d_data", k), pif.pacer_dst_data, model_q[0]);
            check($sformatf("wrap%0d_occ", k), fifo_occupancy, 4'd3);
            next_cycle();
            void'(model_q.pop_front());
            model_q.push_back(32'hF000_0000 + k);
        end
        drive(1'b0, '0, 1'b1, 8'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("wrap_drain%0d_data", k), pif.pacer_dst_data, model_q[0]);
            next_cycle();
            void'(model_q.pop_front());
        end
        @(negedge clk);
        check("wrap_empty_occ", fifo_occupancy, 4'd0);
        next_cycle();

        // Asynchronous reset in the middle of a gap with 5 entries buffered.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'hB000_0000 + i, 1'b0, 8'd4);
            next_cycle();
        end
        drive(1'b0, '0, 1'b1, 8'd4);
        next_cycle();
        @(negedge clk);
        check("gap_pre_rst_val", pif.pacer_dst_val, 1'b0);
        check("gap_pre_rst_occ", fifo_occupancy, 4'd5);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_val", pif.pacer_dst_val, 1'b0);
        check("async_rst_occ", fifo_occupancy, 4'd0);
        check("async_rst_mux_rdy", pif.pacer_mux_rdy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, '0, 1'b1, 8'd0);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post_rst%0d_val", k), pif.pacer_dst_val, 1'b0);
            check($sformatf("post_rst%0d_occ", k), fifo_occupancy, 4'd0);
            next_cycle();
        end
        drive(1'b1, 32'h6666_0001, 1'b1, 8'd0);
        next_cycle();
        drive(1'b0, '0, 1'b1, 8'd0);
        @(negedge clk);
        check("post_rst_new_val", pif.pacer_dst_val, 1'b1);
        check("post_rst_new_data", pif.pacer_dst_data, 32'h6666_0001);
        next_cycle();
        @(negedge clk);
        check("post_rst_new_gone", fifo_occupancy, 4'd0);
        next_cycle();

`ifdef SEND_PKT_PACER_STATS_EN
        // Statistics: 10 packets, each stalled for two cycles.
        rst = 1'b0;
        #1;
        check("stat_rst_pkts", stat_pkts_sent, 32'd0);
        check("stat_rst_stall", stat_stall_cycles, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        for (int p = 0; p < 10; p++) begin
            drive(1'b1, 32'h5000_0000 + p, 1'b0, 8'd0);
            next_cycle();
            drive(1'b0, '0, 1'b0, 8'd0);
            next_cycle();
            next_cycle();
            drive(1'b0, '0, 1'b1, 8'd0);
            next_cycle();
        end
        drive(1'b0, '0, 1'b0, 8'd0);
        @(negedge clk);
        check("stat_pkts_sent", stat_pkts_sent, 32'd10);
        check("stat_stall_cycles", stat_stall_cycles, 32'd20);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/send_pkt_pacer.md
Name: send_pkt_pacer

Overview:
- Sits directly downstream of the two-source send-packet mux.
- Buffers arbitrated send_pkt_struct entries in a small FIFO and releases them to the TX header/assembly stage with a runtime-programmable minimum idle gap between packet handshakes.
- Decouples the mux arbiter from TX backpressure and enforces egress pacing.

Parameters:
- FIFO_DEPTH, 8, number of send_pkt_struct entries buffered; power of two, ≥2.
- GAP_W, 8, width of the gap configuration and the gap counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-low.
- mux_pacer_val  input  1  upstream entry valid.
- mux_pacer_data  input  SEND_PKT_STRUCT_W  upstream entry.
- pacer_mux_rdy  output  1  pacer can accept an entry.
- pacer_dst_val  output  1  entry valid to the TX stage.
- pacer_dst_data  output  SEND_PKT_STRUCT_W  entry to the TX stage.
- dst_pacer_rdy  input  1  TX stage accepts.
- cfg_gap_cycles  input  GAP_W  minimum idle cycles between output handshakes; 0 = back-to-back.
- fifo_occupancy  output  $clog2(FIFO_DEPTH)+1  number of entries currently held.

Behaviour:
- Reset (rst low, async):
  - FIFO empty; read/write pointers 0; occupancy 0.
  - State READY; gap counter 0.
  - pacer_dst_val 0; pacer_dst_data 0.
  - pacer_mux_rdy forced 0 while rst is low.
  - Reset mid-traffic discards all buffered entries.
- Input handshake: push when mux_pacer_val & pacer_mux_rdy.
  - pacer_mux_rdy = !full, from registered state only; no combinational path from dst_pacer_rdy.
  - When full, no push occurs even if a pop happens in the same cycle.
- Latency:
  - An entry pushed into an empty FIFO in cycle t is presented at the output in cycle t+1 at the earliest; no same-cycle bypass.
  - Output is first-word-fall-through from the FIFO head.
- Output: pacer_dst_val = (state==READY) & !empty.
  - pacer_dst_data = head entry when pacer_dst_val is 1, else 0.
  - Pop when pacer_dst_val & dst_pacer_rdy.
  - Once asserted, val and data stay stable until accepted.
- Simultaneous push and pop (not full): occupancy unchanged; pointers both advance, wrapping modulo FIFO_DEPTH.
- State machine:
  - READY → GAP on an output handshake when the sampled cfg_gap_cycles ≠ 0. The gap counter loads cfg_gap_cycles.
  - READY → READY on a handshake when cfg_gap_cycles == 0 (back-to-back allowed).
  - GAP: pacer_dst_val 0; counter decrements each cycle. When the counter equals 1, the state returns to READY on the next edge.
  - Result: exactly cfg_gap_cycles cycles with val low between consecutive handshakes.
  - cfg_gap_cycles is sampled only at the handshake; changes during GAP take effect on the next packet.
- Pushes continue normally during GAP.
- fifo_occupancy is registered and reflects state after the current edge.
  - Range 0..FIFO_DEPTH; full when it equals FIFO_DEPTH.

Optional Feature:
- Macro SEND_PKT_PACER_STATS_EN.
- Defined: adds outputs stat_pkts_sent (32b) and stat_stall_cycles (32b).
  - stat_pkts_sent counts output handshakes.
  - stat_stall_cycles counts cycles with pacer_dst_val & !dst_pacer_rdy.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset release, cfg_gap_cycles=0, dst_pacer_rdy=1, push entries A,B,C on consecutive cycles → output A,B,C on consecutive cycles starting one cycle after A's push; occupancy peaks at 1.
2. cfg_gap_cycles=3, 4 entries preloaded, dst_pacer_rdy=1 → handshakes spaced exactly 4 cycles apart (3 idle cycles each), in FIFO order.
3. dst_pacer_rdy=0, push 9 entries with FIFO_DEPTH=8 → 8 accepted; pacer_mux_rdy low after the 8th; occupancy=8. Release rdy → entries 1..8 out in order. Entry 9 is accepted only on the cycle after the first pop.
4. Simultaneous push/pop over 20 cycles, forcing pointer wrap twice → no loss or reordering; occupancy constant.
5. Assert rst low mid-GAP with 5 entries buffered → pacer_dst_val 0 and occupancy 0 immediately (async). After release the state is READY and the old entries never appear.
6. With SEND_PKT_PACER_STATS_EN: 10 packets with 2 cycles of dst_pacer_rdy low each → stat_pkts_sent=10, stat_stall_cycles=20.
